conv_inbuf: RTL and testbench
=============================

# conv_inbuf

Input-side buffer for a convolution-layer crossbar stage. It receives the activation write stream from the previous layer's functional unit (write-enable, address, data, start) and stores one input vector across all vertical CIM tiles. It then drives the crossbars bit-serially, LSB plane first, and holds off the producer with `o_busy` until the crossbar signals completion.

## Interface
- `input_size`, 201: number of valid input elements per vector.
- `xbar_size`, 256: rows per crossbar tile.
- `datatype_size`, 8: bits per input element; also the number of bit planes streamed.
- `v_cim_tiles`, (input_size + xbar_size - 1) / xbar_size: vertical tile count.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `i_we`  in  1  write strobe from producer.
- `i_addr`  in  $clog2(input_size)  element index of the write.
- `i_data`  in  datatype_size  element value, unsigned.
- `i_start`  in  1  one-cycle pulse: vector complete, begin streaming.
- `o_busy`  out  1  high while streaming or waiting; producer must not write or start.
- `o_plane`  out  [v_cim_tiles-1:0][xbar_size-1:0]  current bit plane, one bit per crossbar row.
- `o_plane_valid`  out  1  `o_plane` valid this cycle.
- `o_plane_idx`  out  $clog2(datatype_size)  bit index of the current plane.
- `o_plane_last`  out  1  high with the plane where `o_plane_idx == datatype_size-1`.
- `i_xbar_done`  in  1  one-cycle pulse from the crossbar/ADC side: accumulation finished.
- `o_err`  out  1  sticky protocol-violation flag.

## Operation
- Storage: `input_size` × `datatype_size` registers. Address `a` maps to tile `a / xbar_size`, row `a % xbar_size`. Rows with global index ≥ `input_size` are padding and always drive 0.
- State `S_IDLE`:
  - `o_busy` = 0.
  - `i_we` with `i_addr < input_size` writes `i_data`. Writes with `i_addr ≥ input_size` are dropped and set `o_err`.
  - `i_start` moves the block to `S_STREAM`.
- State `S_STREAM`:
  - `o_busy` = 1 and `o_plane_valid` = 1.
  - Plane counter k runs 0 to `datatype_size-1`, one plane per cycle. `o_plane[t][r]` is bit k of the stored element.
  - After k = `datatype_size-1`, the block moves to `S_WAIT`.
- State `S_WAIT`:
  - `o_busy` = 1 and `o_plane_valid` = 0.
  - `i_xbar_done` moves the block to `S_IDLE`.
- Protocol violations:
  - Any `i_we` or `i_start` while `o_busy` = 1 is ignored and sets `o_err`.
  - `i_xbar_done` outside `S_WAIT` is ignored; it does not set `o_err`.
- `i_we` and `i_start` asserted in the same `S_IDLE` cycle: the write is committed and is included in the streamed vector.
- Multiple writes to one address: the last write wins.
- `o_err` clears only on reset.

## Timing
- Reset values:
  - state = `S_IDLE`.
  - All storage = 0.
  - `o_busy`, `o_plane_valid`, `o_plane_last`, `o_err` = 0.
  - `o_plane` = 0 and `o_plane_idx` = 0.
- Reset asserted mid-stream or mid-wait aborts immediately; all outputs take their reset values asynchronously.
- Write latency: data written at edge t is visible in planes from edge t+1 onward.
- Stream start:
  - With `i_start` sampled at edge t, `o_busy` and `o_plane_valid` are registered high in cycle t+1 with plane 0.
  - Plane k is driven in cycle t+1+k. `o_plane_last` is high in cycle t+`datatype_size`.
  - `S_WAIT` begins in cycle t+1+`datatype_size`.
- Outputs are registered: `o_plane`, `o_plane_idx`, `o_plane_valid`, `o_plane_last` and `o_busy` are driven from flops, with no combinational path from inputs.
- Release: with `i_xbar_done` sampled at edge d in `S_WAIT`, `o_busy` = 0 from cycle d+1. A new write or `i_start` is accepted at edge d+1.
- Minimum turnaround from `i_start` to the next accepted `i_start`: `datatype_size` + 2 cycles.

## Configuration
- `CONV_INBUF_CLEAR_EN`:
  - Defined: on the `S_WAIT`→`S_IDLE` transition, all storage is zeroed in that same edge. Unwritten elements of the next vector therefore stream as 0.
  - Undefined: storage is retained across vectors, and only addresses that are rewritten change.
  - In both cases, padding rows drive 0.

## Test plan
- Reset, write addr 0 = 8'hA5 and addr 200 = 8'h01, then `i_start` → planes 0..7 show row 0 bits 1,0,1,0,0,1,0,1 and tile 0 row 200 bit set only at plane 0. `o_plane_last` is high on the 8th cycle, and every padding row (201..255) stays 0.
- Assert `i_we` with addr 5 = 8'hFF in the same cycle as `i_start` → row 5 is 1 in all 8 planes.
- With `input_size`=300: write addr 299 = 8'h80 → tile 1 row 43 is 1 only at plane 7. Padding rows 44..255 of tile 1 stay 0.
- Write during `S_WAIT`, then write addr 250 when `input_size`=201 → both writes are ignored, `o_err` = 1 and stays 1 until `rst`.
- Assert `i_xbar_done` during `S_STREAM` → it is ignored and streaming continues. Assert it in `S_WAIT` → `o_busy` falls the next cycle.
- With `CONV_INBUF_CLEAR_EN` defined: run vector 1 with addr 3 = 8'h0F, then start vector 2 with no writes → all planes are 0. With the macro undefined, the same sequence streams addr 3 = 8'h0F again. Then assert `rst` mid-stream → `o_busy`/`o_plane_valid` drop at once.

Source files
------------

// File: rtl/conv_inbuf_if.sv
// rtl/conv_inbuf_if.sv - activation write / bit-plane stream bundle for conv_inbuf
interface conv_inbuf_if #(
  parameter int input_size    = 201,
  parameter int xbar_size     = 256,
  parameter int datatype_size = 8,
  parameter int v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size
);
  logic                                       i_we;
  logic [$clog2(input_size)-1:0]              i_addr;
  logic [datatype_size-1:0]                   i_data;
  logic                                       i_start;
  logic                                       o_busy;
  logic [v_cim_tiles-1:0][xbar_size-1:0]      o_plane;
  logic                                       o_plane_valid;
  logic [$clog2(datatype_size)-1:0]           o_plane_idx;
  logic                                       o_plane_last;
  logic                                       i_xbar_done;
  logic                                       o_err;

  // Producer / crossbar side
  modport master (
    output i_we, i_addr, i_data, i_start, i_xbar_done,
    input  o_busy, o_plane, o_plane_valid, o_plane_idx, o_plane_last, o_err
  );

  // Buffer side
  modport slave (
    input  i_we, i_addr, i_data, i_start, i_xbar_done,
    output o_busy, o_plane, o_plane_valid, o_plane_idx, o_plane_last, o_err
  );
endinterface

// File: rtl/conv_inbuf.sv
// rtl/conv_inbuf.sv - input vector buffer streaming LSB-first bit planes to CIM tiles (option: CONV_INBUF_CLEAR_EN)
module conv_inbuf #(
  parameter int input_size    = 201,
  parameter int xbar_size     = 256,
  parameter int datatype_size = 8,
  parameter int v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size
) (
  input  logic          clk,
  input  logic          rst,
  conv_inbuf_if.slave   bus
);

  localparam int AW = $clog2(input_size);
  localparam int IW = $clog2(datatype_size);
  localparam logic [IW-1:0] LAST_IDX = IW'(datatype_size - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_t;

  state_t                                 state;
  logic [datatype_size-1:0]               mem [input_size];
  logic                                   busy_q;
  logic                                   valid_q;
  logic                                   last_q;
  logic                                   err_q;
  logic [IW-1:0]                          idx_q;
  logic [v_cim_tiles-1:0][xbar_size-1:0]  plane_q;

  logic                                   addr_ok;
  logic                                   wr_en;
  logic                                   err_set;
  logic [IW-1:0]                          k_next;
  logic [v_cim_tiles-1:0][xbar_size-1:0]  plane_next;

  // One extra bit so input_size itself is representable in the compare
  assign addr_ok = ({1'b0, bus.i_addr} < (AW+1)'(input_size));
  assign wr_en   = (state == S_IDLE) && bus.i_we && addr_ok;
  assign err_set = ((state == S_IDLE) && bus.i_we && !addr_ok) ||
                   ((state != S_IDLE) && (bus.i_we || bus.i_start));

  // Plane index that will be registered at the coming edge
  assign k_next = (state == S_STREAM) ? idx_q + 1'b1 : '0;

  // Next bit plane; a write in the start cycle is forwarded so it joins the vector
  always_comb begin
    logic [datatype_size-1:0] elem;
    plane_next = '0;
    for (int e = 0; e < input_size; e++) begin
      elem = mem[e];
      if (wr_en && (bus.i_addr == AW'(e)))
        elem = bus.i_data;
      plane_next[e / xbar_size][e % xbar_size] = elem[k_next];
    end
  end

  // Element storage: producer writes while idle, optional wipe on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < input_size; i++)
        mem[i] <= '0;
    end else begin
`ifdef CONV_INBUF_CLEAR_EN
      if ((state == S_WAIT) && bus.i_xbar_done) begin
        for (int i = 0; i < input_size; i++)
          mem[i] <= '0;
      end else if (wr_en) begin
        mem[bus.i_addr] <= bus.i_data;
      end
`else
      if (wr_en)
        mem[bus.i_addr] <= bus.i_data;
`endif
    end
  end

  // Control FSM with registered plane outputs and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      plane_q <= '0;
    end else begin
      if (err_set)
        err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            state   <= S_STREAM;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            idx_q   <= '0;
            last_q  <= (LAST_IDX == '0);
            plane_q <= plane_next;
          end
        end
        S_STREAM: begin
          if (idx_q == LAST_IDX) begin
            state   <= S_WAIT;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            plane_q <= '0;
          end else begin
            idx_q   <= k_next;
            last_q  <= (k_next == LAST_IDX);
            plane_q <= plane_next;
          end
        end
        S_WAIT: begin
          if (bus.i_xbar_done) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_plane_valid = valid_q;
  assign bus.o_plane_last  = last_q;
  assign bus.o_plane_idx   = idx_q;
  assign bus.o_plane       = plane_q;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_conv_inbuf.sv
// tb/tb_conv_inbuf.sv - directed self-checking bench for conv_inbuf
module tb_conv_inbuf;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef CONV_INBUF_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  always #5 clk = ~clk;

  conv_inbuf_if #(.input_size(201)) bus ();
  conv_inbuf_if #(.input_size(300)) bus3 ();

  conv_inbuf #(.input_size(201)) dut (.clk(clk), .rst(rst), .bus(bus));
  conv_inbuf #(.input_size(300)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [7:0] ref_mem [201];

  function automatic logic [255:0] exp_plane(input int k);
    logic [255:0] p;
    p = '0;
    for (int e = 0; e < 201; e++)
      p[e] = ref_mem[e][k];
    return p;
  endfunction

  task automatic clear_ref();
    for (int e = 0; e < 201; e++)
      ref_mem[e] = 8'h00;
  endtask

  task automatic write_elem(input int a, input logic [7:0] d);
    bus.i_we   = 1'b1;
    bus.i_addr = 8'(a);
    bus.i_data = d;
    @(negedge clk);
    bus.i_we = 1'b0;
    if (a < 201)
      ref_mem[a] = d;
  endtask

  task automatic start_stream();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Entered at the negedge of the plane-0 cycle; leaves the block idle
  task automatic check_stream(input string tag, input int early_done_k);
    logic [5:0]   exp_s;
    logic [5:0]   got_s;
    logic [255:0] got_p;
    logic [255:0] exp_p;
    for (int k = 0; k < 8; k++) begin
      exp_s = {1'b1, 1'b1, (k == 7), 3'(k)};
      got_s = {bus.o_busy, bus.o_plane_valid, bus.o_plane_last, bus.o_plane_idx};
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("FAIL %s status k=%0d: got busy/valid/last/idx=%b want %b", tag, k, got_s, exp_s);
      end
      got_p = bus.o_plane;
      exp_p = exp_plane(k);
      checks++;
      if (got_p !== exp_p) begin
        errors++;
        $display("FAIL %s plane k=%0d: got %h want %h", tag, k, got_p, exp_p);
      end
      bus.i_xbar_done = (k == early_done_k);
      @(negedge clk);
    end
    bus.i_xbar_done = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_plane_valid, bus.o_plane_last} !== 3'b100) begin
      errors++;
      $display("FAIL %s wait_entry: got busy/valid/last=%b want 100", tag,
               {bus.o_busy, bus.o_plane_valid, bus.o_plane_last});
    end
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_hold: got busy=%b want 1", tag, bus.o_busy);
    end
    bus.i_xbar_done = 1'b1;
    @(negedge clk);
    bus.i_xbar_done = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_plane_valid} !== 2'b00) begin
      errors++;
      $display("FAIL %s release: got busy/valid=%b want 00", tag, {bus.o_busy, bus.o_plane_valid});
    end
    if (CLEAR)
      clear_ref();
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.o_busy, bus.o_plane_valid, bus.o_plane_last, bus.o_err, bus.o_plane_idx} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000",
               {bus.o_busy, bus.o_plane_valid, bus.o_plane_last, bus.o_err, bus.o_plane_idx});
    end
    checks++;
    if (bus.o_plane !== 256'b0) begin
      errors++;
      $display("FAIL reset_plane: got %h want 0", bus.o_plane);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_stream();
    write_elem(0, 8'hA5);
    write_elem(200, 8'h01);
    start_stream();
    check_stream("basic", -1);
  endtask

  task automatic test_write_with_start();
    bus.i_we    = 1'b1;
    bus.i_addr  = 8'd5;
    bus.i_data  = 8'hFF;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_we    = 1'b0;
    bus.i_start = 1'b0;
    ref_mem[5] = 8'hFF;
    check_stream("we_start", -1);
  endtask

  task automatic test_done_in_stream();
    write_elem(17, 8'h5A);
    start_stream();
    check_stream("done_mid", 3);
  endtask

  task automatic test_clear_behaviour();
    write_elem(3, 8'h0F);
    start_stream();
    check_stream("vec1", -1);
    start_stream();
    check_stream("vec2", -1);
  endtask

  task automatic test_protocol_errors();
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got %b want 0", bus.o_err);
    end
    start_stream();
    repeat (8) @(negedge clk);
    bus.i_we   = 1'b1;
    bus.i_addr = 8'd7;
    bus.i_data = 8'h33;
    @(negedge clk);
    bus.i_we = 1'b0;
    checks++;
    if ({bus.o_err, bus.o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL err_wait_write: got err/busy=%b want 11", {bus.o_err, bus.o_busy});
    end
    bus.i_xbar_done = 1'b1;
    @(negedge clk);
    bus.i_xbar_done = 1'b0;
    if (CLEAR)
      clear_ref();
    write_elem(250, 8'hEE);
    checks++;
    if ({bus.o_err, bus.o_busy} !== 2'b10) begin
      errors++;
      $display("FAIL err_oob_write: got err/busy=%b want 10", {bus.o_err, bus.o_busy});
    end
    start_stream();
    check_stream("after_err", -1);
    checks++;
    if (bus.o_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", bus.o_err);
    end
  endtask

  task automatic test_size300();
    logic [511:0] exp_p;
    logic [511:0] got_p;
    bus3.i_we   = 1'b1;
    bus3.i_addr = 9'd299;
    bus3.i_data = 8'h80;
    @(negedge clk);
    bus3.i_we    = 1'b0;
    bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_p = '0;
      exp_p[256 + 43] = (k == 7);
      got_p = bus3.o_plane;
      checks++;
      if (got_p !== exp_p || bus3.o_plane_idx !== 3'(k)) begin
        errors++;
        $display("FAIL size300 k=%0d: got idx=%0d plane=%h want idx=%0d plane=%h",
                 k, bus3.o_plane_idx, got_p, k, exp_p);
      end
      @(negedge clk);
    end
    bus3.i_xbar_done = 1'b1;
    @(negedge clk);
    bus3.i_xbar_done = 1'b0;
    checks++;
    if ({bus3.o_busy, bus3.o_err} !== 2'b00) begin
      errors++;
      $display("FAIL size300_release: got busy/err=%b want 00", {bus3.o_busy, bus3.o_err});
    end
  endtask

  task automatic test_reset_midstream();
    write_elem(9, 8'hC3);
    start_stream();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_plane_valid, bus.o_plane_last, bus.o_err} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_flags: got busy/valid/last/err=%b want 0000",
               {bus.o_busy, bus.o_plane_valid, bus.o_plane_last, bus.o_err});
    end
    checks++;
    if (bus.o_plane !== 256'b0 || bus.o_plane_idx !== 3'd0) begin
      errors++;
      $display("FAIL async_reset_plane: got idx=%0d plane=%h want 0", bus.o_plane_idx, bus.o_plane);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_ref();
    @(negedge clk);
    start_stream();
    check_stream("post_reset", -1);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_we = 1'b0;  bus.i_addr = '0;  bus.i_data = '0;
    bus.i_start = 1'b0;  bus.i_xbar_done = 1'b0;
    bus3.i_we = 1'b0; bus3.i_addr = '0; bus3.i_data = '0;
    bus3.i_start = 1'b0; bus3.i_xbar_done = 1'b0;
    clear_ref();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_stream();
    test_write_with_start();
    test_done_in_stream();
    test_clear_behaviour();
    test_size300();
    test_protocol_errors();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
